// File: rtl/mantissa_align_if.sv
// Operand/result bundle between the exponent comparator, the alignment stage and the adder.
// The slave modport is the alignment stage; the master modport is its environment.
interface mantissa_align_if #(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8
);
   logic                valid_in;
   logic                ready_in;
   logic [MANT_W-1:0]   mantissa_a;
   logic [MANT_W-1:0]   mantissa_b;
   logic [EXP_W-1:0]    exponent_a;
   logic [EXP_W-1:0]    exponent_b;
   logic [EXP_W-1:0]    difference;
   logic                zero_flag;
   logic                greater_flag;
   logic                lesser_flag;
   logic                valid_out;
   logic                ready_out;
   logic [MANT_W+2:0]   aligned_a;
   logic [MANT_W+2:0]   aligned_b;
   logic [EXP_W-1:0]    exponent_out;
   logic                flag_err;

   modport master (
      output valid_in, mantissa_a, mantissa_b, exponent_a, exponent_b, difference,
             zero_flag, greater_flag, lesser_flag, ready_out,
      input  ready_in, valid_out, aligned_a, aligned_b, exponent_out, flag_err
   );

   modport slave (
      input  valid_in, mantissa_a, mantissa_b, exponent_a, exponent_b, difference,
             zero_flag, greater_flag, lesser_flag, ready_out,
      output ready_in, valid_out, aligned_a, aligned_b, exponent_out, flag_err
   );
endinterface

// File: rtl/mantissa_align.sv
// Floating-point add/sub alignment stage: right-shifts the smaller operand's significand
// one bit per cycle by the exponent difference, keeping guard/round/sticky bits.
module mantissa_align #(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8
) (
   input logic               clk,
   input logic               rst,
   mantissa_align_if.slave   bus
);

   localparam int AW = MANT_W + 3;
   localparam logic [EXP_W:0] SAT_LIMIT = (EXP_W+1)'(AW);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     alignedA_q, alignedA_d;
   logic [AW-1:0]     alignedB_q, alignedB_d;
   logic [EXP_W-1:0]  exponentOut_q, exponentOut_d;
   logic [EXP_W-1:0]  count_q, count_d;
   logic              flagErr_q, flagErr_d;
   logic              shiftA_q, shiftA_d;

   logic              flagsOneHot;
   logic              shiftA;
   logic              shiftB;
   logic              diffZero;
   logic              diffSat;

   function automatic logic [AW-1:0] shiftOne(input logic [AW-1:0] v);
      return {1'b0, v[AW-1:2], v[1] | v[0]};
   endfunction

   // Non-one-hot flags degrade to the equal-exponent case: no shift, exponent A.
   assign flagsOneHot = ({bus.zero_flag, bus.greater_flag, bus.lesser_flag} == 3'b100) ||
                        ({bus.zero_flag, bus.greater_flag, bus.lesser_flag} == 3'b010) ||
                        ({bus.zero_flag, bus.greater_flag, bus.lesser_flag} == 3'b001);
   assign shiftA   = flagsOneHot && bus.lesser_flag;
   assign shiftB   = flagsOneHot && bus.greater_flag;
   assign diffZero = (bus.difference == '0);
   assign diffSat  = ({1'b0, bus.difference} >= SAT_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         alignedA_q    <= '0;
         alignedB_q    <= '0;
         exponentOut_q <= '0;
         count_q       <= '0;
         flagErr_q     <= 1'b0;
         shiftA_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         alignedA_q    <= alignedA_d;
         alignedB_q    <= alignedB_d;
         exponentOut_q <= exponentOut_d;
         count_q       <= count_d;
         flagErr_q     <= flagErr_d;
         shiftA_q      <= shiftA_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      alignedA_d    = alignedA_q;
      alignedB_d    = alignedB_q;
      exponentOut_d = exponentOut_q;
      count_d       = count_q;
      flagErr_d     = flagErr_q;
      shiftA_d      = shiftA_q;
      case (state_q)
         IDLE: begin
            if (bus.valid_in) begin
               alignedA_d    = {bus.mantissa_a, 3'b000};
               alignedB_d    = {bus.mantissa_b, 3'b000};
               exponentOut_d = shiftA ? bus.exponent_b : bus.exponent_a;
               flagErr_d     = !flagsOneHot;
               shiftA_d      = shiftA;
               count_d       = bus.difference;
               if (!(shiftA || shiftB) || diffZero) begin
                  state_d = DONE;
               end else if (diffSat) begin
                  // Everything falls off the end; only the sticky bit survives.
                  if (shiftA) alignedA_d = {{(AW-1){1'b0}}, |bus.mantissa_a};
                  else        alignedB_d = {{(AW-1){1'b0}}, |bus.mantissa_b};
                  state_d = DONE;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (shiftA_q) alignedA_d = shiftOne(alignedA_q);
            else          alignedB_d = shiftOne(alignedB_q);
            count_d = count_q - EXP_W'(1);
            if (count_q == EXP_W'(1)) state_d = DONE;
         end
         DONE: begin
            if (bus.ready_out) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.ready_in     = (state_q == IDLE);
      bus.valid_out    = (state_q == DONE);
      bus.aligned_a    = alignedA_q;
      bus.aligned_b    = alignedB_q;
      bus.exponent_out = exponentOut_q;
      bus.flag_err     = flagErr_q;
   end

endmodule
